// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: head-of-FIFO byte with valid/ready
// handshake, plus the single-cycle error pulses.
interface uart_rx_fifo_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       FRAME_ERR;
  logic       OVERRUN;

  modport master (output DATA, output VALID, output FRAME_ERR, output OVERRUN, input READY);
  modport slave  (input DATA, input VALID, input FRAME_ERR, input OVERRUN, output READY);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchroniser, a mid-bit sampling FSM and a
// small pointer-based FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RXD,
  uart_rx_fifo_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_overrun;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_stop_tick;
  logic w_push;
  logic w_drop;
  logic w_ferr;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop       = !w_empty && bus.READY;
  assign w_stop_tick = (r_state == S_STOP) && (r_clk_cnt == FULL_LAST);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
  assign w_push      = w_stop_tick && r_rx_s && (!w_full || w_pop);
  assign w_drop      = w_stop_tick && r_rx_s && w_full && !w_pop;
  assign w_ferr      = w_stop_tick && !r_rx_s;

  // Synchroniser stage: idle-high line, so both flops reset to 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RXD;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame FSM stage: start bit checked at mid-bit, data and stop bits a full bit later each.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (!r_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == FULL_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          r_clk_cnt <= '0;
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status pulse stage: high only in the cycle after the stop sample.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_drop;
    end
  end

  // FIFO stage: pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  // Storage is not reset, so the head is forced to zero while nothing is valid.
  assign bus.DATA      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.VALID     = !w_empty;
  assign bus.FRAME_ERR = r_frame_err;
  assign bus.OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are generated from byte values
// and the delivered byte stream is compared with a queue-based receive model.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic RXD = 1'b1;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] got_q [$];
  int   fe_cnt, ovr_cnt, val_cycles, rise_cyc;
  logic prev_valid  = 1'b0;
  logic rand_ready  = 1'b0;
  logic ready_fixed = 1'b1;

  always @(posedge CLK) cyc++;

  initial forever begin
    bus.READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    @(posedge CLK);
    #1;
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (bus.VALID && bus.READY) got_q.push_back(bus.DATA);
      if (bus.VALID) val_cycles++;
      if (bus.VALID && !prev_valid) rise_cyc = cyc;
      if (bus.FRAME_ERR) fe_cnt++;
      if (bus.OVERRUN) ovr_cnt++;
    end
    prev_valid = bus.VALID;
  end

  task automatic clear_mon();
    got_q.delete();
    fe_cnt = 0; ovr_cnt = 0; val_cycles = 0; rise_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Frame is {stop, data LSB-first, start}, each bit held CPB clocks.
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = fr[i];
      repeat (CPB) @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    idle(3);
    vectors++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.VALID); end
    vectors++; if (bus.DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.DATA); end
    vectors++; if (bus.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.FRAME_ERR); end
    vectors++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", bus.OVERRUN); end
    RST = 1'b1;
    idle(5);
    vectors++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", bus.VALID); end
  endtask

  task automatic test_single();
    int t0, lat;
    clear_mon();
    ready_fixed = 1'b1;
    idle(2);
    t0 = cyc;
    uart_send(8'hA5, 1'b1);
    idle(40);
    lat = rise_cyc - t0;
    vectors++; if (lat < 150 || lat > 160) begin errors++; $display("FAIL single_latency: got %0d expected 150..160", lat); end
    vectors++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", got_q[0]); end
    end
    vectors++; if (val_cycles != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", val_cycles); end
    vectors++; if (fe_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL single_pulses: got fe=%0d ovr=%0d expected 0/0", fe_cnt, ovr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    clear_mon();
    exp_q = {8'h00, 8'hFF};
    foreach (exp_q[i]) uart_send(exp_q[i], 1'b1);
    idle(40);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    RXD = 1'b0;
    idle(4);
    RXD = 1'b1;
    idle(200);
    vectors++; if (val_cycles != 0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", val_cycles); end
    vectors++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt); end
    uart_send(8'h5A, 1'b1);
    idle(40);
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin errors++; $display("FAIL glitch_recover: got %0d bytes expected one 5a", got_q.size()); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    uart_send(8'h3C, 1'b0);
    RXD = 1'b0;
    idle(40);
    RXD = 1'b1;
    idle(40);
    vectors++; if (fe_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt); end
    vectors++; if (val_cycles != 0) begin errors++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", val_cycles); end
    clear_mon();
    uart_send(8'h11, 1'b1);
    idle(40);
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin errors++; $display("FAIL ferr_recover: got %0d bytes expected one 11", got_q.size()); end
    vectors++; if (fe_cnt != 0) begin errors++; $display("FAIL ferr_recover_pulse: got %0d expected 0", fe_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [$];
    int ovr_exp;
    clear_mon();
    ready_fixed = 1'b0;
    ovr_exp = 0;
    idle(2);
    for (int b = 1; b <= 5; b++) begin
      uart_send(8'(b), 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(b));
      else ovr_exp++;
    end
    idle(30);
    vectors++; if (ovr_cnt != ovr_exp) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", ovr_cnt, ovr_exp); end
    vectors++; if (bus.VALID !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.VALID); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus.DATA !== exp_q[0]) begin errors++; $display("FAIL ovr_head_stable: got %h expected %h", bus.DATA, exp_q[0]); end
      idle(3);
    end
    ready_fixed = 1'b1;
    idle(20);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_drain%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (bus.VALID !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall: got %b expected 0", bus.VALID); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_mon();
    b = 8'h77;
    RXD = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      RXD = b[i];
      idle(CPB);
    end
    #2 RST = 1'b0;
    idle(3);
    vectors++; if (bus.VALID !== 1'b0 || bus.DATA !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got valid=%b data=%h expected 0/00", bus.VALID, bus.DATA); end
    vectors++; if (bus.FRAME_ERR !== 1'b0 || bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got fe=%b ovr=%b expected 0/0", bus.FRAME_ERR, bus.OVERRUN); end
    RXD = 1'b1;
    idle(2);
    RST = 1'b1;
    idle(20);
    uart_send(8'h42, 1'b1);
    idle(40);
    vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h42) begin errors++; $display("FAIL midrst_deliver: got %0d bytes expected one 42", got_q.size()); end
    vectors++; if (fe_cnt != 0) begin errors++; $display("FAIL midrst_ferr: got %0d expected 0", fe_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    clear_mon();
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      uart_send(b, 1'b1);
      idle(CPB * $urandom_range(0, 2));
    end
    idle(60);
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    idle(10);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (ovr_cnt != 0 || fe_cnt != 0) begin errors++; $display("FAIL rand_pulses: got ovr=%0d fe=%0d expected 0/0", ovr_cnt, fe_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
